// File: rtl/ro_data_receiver.sv
// ro_data_receiver
// Receive-side deserializer for the ring-oscillator count serial link.
// Samples DATA_IN and the C_IN frame-select lines on every data_clk rising
// edge, aligns to 128-bit frames using select-line transitions, and publishes
// the INV/NAND/NOR/CLK counts with a valid pulse, frame ID and error flags.
//
// Link timing: the sample on which C_IN changes carries bit 127 of the ending
// frame, and the following sample is bit 0 of the next frame.

module ro_data_receiver #(
  parameter logic CHECK_SEQ = 1'b1,
  parameter int   ERR_CNT_W = 8
) (
  input  logic                 data_clk,
  input  logic                 reset,
  input  logic                 DATA_IN,
  input  logic [1:0]           C_IN,
  output logic [31:0]          INV_COUNT,
  output logic [31:0]          NAND_COUNT,
  output logic [31:0]          NOR_COUNT,
  output logic [31:0]          CLK_COUNT,
  output logic [1:0]           FRAME_ID,
  output logic                 FRAME_VALID,
  output logic                 SYNC_ERR,
  output logic                 SEQ_ERR,
  output logic                 LOCKED,
  output logic [ERR_CNT_W-1:0] ERR_COUNT
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [6:0] LAST_BIT = 7'd127;

  state_t       state;
  state_t       state_next;
  logic [6:0]   bit_idx;
  logic [6:0]   bit_idx_next;
  logic [1:0]   c_prev;
  logic         transition;

  // Only the first 127 bits of a frame are ever stored; bit 127 is taken
  // straight from DATA_IN on the sample that completes the frame.
  logic [126:0] shreg;
  logic [127:0] frame_word;

  logic         shift_en;
  logic         good_frame;
  logic         sync_evt;
  logic         seq_evt;

  assign transition = (C_IN != c_prev);
  assign frame_word = {DATA_IN, shreg};

  // Frame alignment: decide the next state, bit position and frame events.
  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    shift_en     = 1'b0;
    good_frame   = 1'b0;
    sync_evt     = 1'b0;
    seq_evt      = 1'b0;

    case (state)
      HUNT: begin
        if (transition) begin
          state_next   = RECV;
          bit_idx_next = 7'd0;
        end
      end

      RECV: begin
        shift_en = 1'b1;
        if (bit_idx == LAST_BIT) begin
          bit_idx_next = 7'd0;
          if (transition) begin
            good_frame = 1'b1;
            seq_evt    = CHECK_SEQ & (C_IN != 2'(c_prev + 2'd1));
          end else begin
            sync_evt   = 1'b1;
            state_next = HUNT;
          end
        end else if (transition) begin
          sync_evt     = 1'b1;
          bit_idx_next = 7'd0;
        end else begin
          bit_idx_next = bit_idx + 7'd1;
        end
      end

      default: begin
        state_next   = HUNT;
        bit_idx_next = 7'd0;
      end
    endcase
  end

  // State, bit counter and previous-select registers.
  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      state   <= HUNT;
      bit_idx <= 7'd0;
      c_prev  <= 2'd0;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
      c_prev  <= C_IN;
    end
  end

  // Serial shift register, LSB first, new bits enter at the top.
  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {DATA_IN, shreg[126:1]};
    end
  end

  // Published counts and frame ID; these hold between good frames.
  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      INV_COUNT  <= 32'd0;
      NAND_COUNT <= 32'd0;
      NOR_COUNT  <= 32'd0;
      CLK_COUNT  <= 32'd0;
      FRAME_ID   <= 2'd0;
    end else if (good_frame) begin
      INV_COUNT  <= frame_word[31:0];
      NAND_COUNT <= frame_word[63:32];
      NOR_COUNT  <= frame_word[95:64];
      CLK_COUNT  <= frame_word[127:96];
      FRAME_ID   <= c_prev;
    end
  end

  // Single-cycle status pulses and the lock indicator.
  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      FRAME_VALID <= 1'b0;
      SYNC_ERR    <= 1'b0;
      SEQ_ERR     <= 1'b0;
      LOCKED      <= 1'b0;
    end else begin
      FRAME_VALID <= good_frame;
      SYNC_ERR    <= sync_evt;
      SEQ_ERR     <= seq_evt;
      if (good_frame) begin
        LOCKED <= 1'b1;
      end else if (sync_evt) begin
        LOCKED <= 1'b0;
      end
    end
  end

  // Saturating error counter, one step per cycle with an error pulse showing.
  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      ERR_COUNT <= '0;
    end else if ((SYNC_ERR | SEQ_ERR) && (ERR_COUNT != '1)) begin
      ERR_COUNT <= ERR_COUNT + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ro_data_receiver.sv
// tb_ro_data_receiver
// Directed bench for ro_data_receiver. The stimulus thread plays the
// transmitter and queues the expected pulse for every frame end; a monitor
// pops and compares whenever FRAME_VALID or SYNC_ERR shows up.

module tb_ro_data_receiver;

  logic        data_clk = 1'b0;
  logic        reset;
  logic        DATA_IN;
  logic [1:0]  C_IN;

  logic [31:0] INV_COUNT, NAND_COUNT, NOR_COUNT, CLK_COUNT;
  logic [1:0]  FRAME_ID;
  logic        FRAME_VALID, SYNC_ERR, SEQ_ERR, LOCKED;
  logic [7:0]  ERR_COUNT;

  logic [31:0] nsInv, nsNand, nsNor, nsClk;
  logic [1:0]  nsFrameId;
  logic        nsFrameValid, nsSyncErr, nsSeqErr, nsLocked;
  logic [7:0]  nsErrCount;

  int assertCount = 0;
  int failCount   = 0;
  int nsSeqPulses = 0;
  int nsValidPulses = 0;

  typedef struct {
    bit          isFrame;
    logic [1:0]  id;
    bit          seqErr;
    logic [31:0] invC;
    logic [31:0] nandC;
    logic [31:0] norC;
    logic [31:0] clkC;
  } expT;

  expT         expQ[$];
  logic [31:0] lastInv = 32'd0;

  ro_data_receiver #(.CHECK_SEQ(1'b1), .ERR_CNT_W(8)) dut (
    .data_clk(data_clk), .reset(reset), .DATA_IN(DATA_IN), .C_IN(C_IN),
    .INV_COUNT(INV_COUNT), .NAND_COUNT(NAND_COUNT), .NOR_COUNT(NOR_COUNT),
    .CLK_COUNT(CLK_COUNT), .FRAME_ID(FRAME_ID), .FRAME_VALID(FRAME_VALID),
    .SYNC_ERR(SYNC_ERR), .SEQ_ERR(SEQ_ERR), .LOCKED(LOCKED),
    .ERR_COUNT(ERR_COUNT)
  );

  ro_data_receiver #(.CHECK_SEQ(1'b0), .ERR_CNT_W(8)) dutNoSeq (
    .data_clk(data_clk), .reset(reset), .DATA_IN(DATA_IN), .C_IN(C_IN),
    .INV_COUNT(nsInv), .NAND_COUNT(nsNand), .NOR_COUNT(nsNor),
    .CLK_COUNT(nsClk), .FRAME_ID(nsFrameId), .FRAME_VALID(nsFrameValid),
    .SYNC_ERR(nsSyncErr), .SEQ_ERR(nsSeqErr), .LOCKED(nsLocked),
    .ERR_COUNT(nsErrCount)
  );

  // Free-running sampling clock.
  always #5 data_clk = ~data_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one serial sample; it is captured on the following rising edge.
  task automatic applyStimulus(input logic d, input logic [1:0] c);
    @(negedge data_clk);
    DATA_IN = d;
    C_IN    = c;
  endtask

  task automatic pushSync();
    expT e;
    e.isFrame = 1'b0; e.id = 2'd0; e.seqErr = 1'b0;
    e.invC = 32'd0; e.nandC = 32'd0; e.norC = 32'd0; e.clkC = 32'd0;
    expQ.push_back(e);
  endtask

  // One transmitter frame: bits 0..126 with cCur, bit 127 with cNext.
  task automatic sendFrame(input logic [1:0] cCur, input logic [1:0] cNext,
                           input logic [31:0] invV, input logic [31:0] nandV,
                           input logic [31:0] norV, input logic [31:0] clkV,
                           input bit publish, input bit seqErr);
    logic [127:0] frame;
    expT e;
    frame = {clkV, norV, nandV, invV};
    if (publish) begin
      e.isFrame = 1'b1; e.id = cCur; e.seqErr = seqErr;
      e.invC = invV; e.nandC = nandV; e.norC = norV; e.clkC = clkV;
      expQ.push_back(e);
      lastInv = invV;
    end
    for (int i = 0; i < 127; i++) applyStimulus(frame[i], cCur);
    applyStimulus(frame[127], cNext);
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge data_clk) begin
    expT e;
    if (reset) begin
      if (nsSeqErr) nsSeqPulses++;
      if (nsFrameValid) nsValidPulses++;
      if (SEQ_ERR && !FRAME_VALID) checkOutput("seq_without_valid", 32'(FRAME_VALID), 32'd1);
      if (FRAME_VALID || SYNC_ERR) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_pulse: got VALID=%0b SYNC=%0b, expected no pulse",
                   FRAME_VALID, SYNC_ERR);
        end else begin
          e = expQ.pop_front();
          checkOutput("pulse_is_frame", 32'(FRAME_VALID), 32'(e.isFrame));
          if (e.isFrame) begin
            checkOutput("inv_count", INV_COUNT, e.invC);
            checkOutput("nand_count", NAND_COUNT, e.nandC);
            checkOutput("nor_count", NOR_COUNT, e.norC);
            checkOutput("clk_count", CLK_COUNT, e.clkC);
            checkOutput("frame_id", 32'(FRAME_ID), 32'(e.id));
            checkOutput("seq_err", 32'(SEQ_ERR), 32'(e.seqErr));
            checkOutput("sync_with_valid", 32'(SYNC_ERR), 32'd0);
            checkOutput("locked_on_frame", 32'(LOCKED), 32'd1);
          end else begin
            checkOutput("locked_on_sync", 32'(LOCKED), 32'd0);
            checkOutput("seq_on_sync", 32'(SEQ_ERR), 32'd0);
          end
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    logic [1:0] c;
    reset = 1'b0; DATA_IN = 1'b0; C_IN = 2'd0;
    #1;
    checkOutput("rst_inv", INV_COUNT, 32'd0);
    checkOutput("rst_nand", NAND_COUNT, 32'd0);
    checkOutput("rst_nor", NOR_COUNT, 32'd0);
    checkOutput("rst_clk", CLK_COUNT, 32'd0);
    checkOutput("rst_frame_id", 32'(FRAME_ID), 32'd0);
    checkOutput("rst_valid", 32'(FRAME_VALID), 32'd0);
    checkOutput("rst_sync", 32'(SYNC_ERR), 32'd0);
    checkOutput("rst_seq", 32'(SEQ_ERR), 32'd0);
    checkOutput("rst_locked", 32'(LOCKED), 32'd0);
    checkOutput("rst_err_count", 32'(ERR_COUNT), 32'd0);
    repeat (3) @(negedge data_clk);
    reset = 1'b1;

    // Back-to-back frames 0->1->2->3->0->1; the first one is discarded.
    sendFrame(2'd0, 2'd1, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hDEADBEEF, 1'b0, 1'b0);
    sendFrame(2'd1, 2'd2, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hDEADBEEF, 1'b1, 1'b0);
    sendFrame(2'd2, 2'd3, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hDEADBEEF, 1'b1, 1'b0);
    sendFrame(2'd3, 2'd0, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hDEADBEEF, 1'b1, 1'b0);
    sendFrame(2'd0, 2'd1, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hDEADBEEF, 1'b1, 1'b0);
    @(posedge data_clk); #1;
    checkOutput("locked_after_stream", 32'(LOCKED), 32'd1);
    checkOutput("err_after_stream", 32'(ERR_COUNT), 32'd0);

    // Early select change at bit 60 of a locked frame.
    for (int i = 0; i < 60; i++) applyStimulus(i[0], 2'd1);
    pushSync();
    applyStimulus(1'b0, 2'd2);
    @(posedge data_clk); #1;
    checkOutput("locked_after_early", 32'(LOCKED), 32'd0);
    checkOutput("inv_held_after_early", INV_COUNT, lastInv);
    sendFrame(2'd2, 2'd3, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'hFFFF0000, 1'b1, 1'b0);
    @(posedge data_clk); #1;
    checkOutput("locked_after_recover", 32'(LOCKED), 32'd1);
    checkOutput("err_after_early", 32'(ERR_COUNT), 32'd1);

    // Select held for 200 samples: late error at bit 127, then hunt.
    pushSync();
    for (int i = 0; i < 200; i++) applyStimulus(i[1], 2'd3);
    @(posedge data_clk); #1;
    checkOutput("locked_after_late", 32'(LOCKED), 32'd0);
    checkOutput("err_after_late", 32'(ERR_COUNT), 32'd2);
    applyStimulus(1'b1, 2'd0);
    sendFrame(2'd0, 2'd1, 32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h5A5AA5A5, 1'b1, 1'b0);
    @(posedge data_clk); #1;
    checkOutput("locked_after_hunt", 32'(LOCKED), 32'd1);

    // Select skips 1->3: published with SEQ_ERR; then 3->0 is clean.
    sendFrame(2'd1, 2'd3, 32'h13579BDF, 32'h2468ACE0, 32'h00FF00FF, 32'h76543210, 1'b1, 1'b1);
    sendFrame(2'd3, 2'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h11111111, 32'h80000001, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0);
    @(posedge data_clk); #1;
    checkOutput("err_after_seq", 32'(ERR_COUNT), 32'd3);
    checkOutput("noseq_err_count", 32'(nsErrCount), 32'd2);
    checkOutput("noseq_seq_pulses", 32'(nsSeqPulses), 32'd0);
    checkOutput("noseq_valid_pulses", 32'(nsValidPulses), 32'd8);

    // Asynchronous reset mid-cycle at bit 90, then first-frame discard.
    for (int i = 1; i <= 90; i++) applyStimulus(i[0], 2'd0);
    @(posedge data_clk); #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_inv", INV_COUNT, 32'd0);
    checkOutput("async_rst_clk", CLK_COUNT, 32'd0);
    checkOutput("async_rst_frame_id", 32'(FRAME_ID), 32'd0);
    checkOutput("async_rst_locked", 32'(LOCKED), 32'd0);
    checkOutput("async_rst_err", 32'(ERR_COUNT), 32'd0);
    for (int i = 91; i <= 95; i++) applyStimulus(i[0], 2'd0);
    reset = 1'b1;
    for (int i = 96; i <= 126; i++) applyStimulus(i[0], 2'd0);
    applyStimulus(1'b1, 2'd1);
    sendFrame(2'd1, 2'd2, 32'hFEDCBA98, 32'h0000FFFF, 32'h33CC33CC, 32'h0BADF00D, 1'b1, 1'b0);
    @(posedge data_clk); #1;
    checkOutput("locked_after_reset", 32'(LOCKED), 32'd1);

    // 300 consecutive early transitions saturate the error counter.
    c = 2'd2;
    for (int i = 0; i < 300; i++) begin
      c = c + 2'd1;
      pushSync();
      applyStimulus(1'b0, c);
    end
    repeat (3) applyStimulus(1'b0, c);
    @(posedge data_clk); #1;
    checkOutput("err_saturated", 32'(ERR_COUNT), 32'd255);
    checkOutput("locked_after_burst", 32'(LOCKED), 32'd0);
    for (int i = 0; i < 5; i++) begin
      c = c + 2'd1;
      pushSync();
      applyStimulus(1'b1, c);
    end
    repeat (4) applyStimulus(1'b0, c);
    @(posedge data_clk); #1;
    checkOutput("err_holds_255", 32'(ERR_COUNT), 32'd255);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ro_data_receiver.md
Name: ro_data_receiver

Overview:
- Receive-side deserializer for the ring-oscillator count serial link, on the bench/capture end.
- Samples the 1-bit serial data and the 2-bit frame select lines on each data_clk rising edge.
- Aligns to 128-bit frames using the select-line transitions, and rebuilds the INV, NAND, NOR and CLK 32-bit counts.
- Publishes each completed frame with a valid pulse, frame ID and sync/sequence error flags.

Parameters:
- CHECK_SEQ, 1, when 1 flag SEQ_ERR if a new select value is not the previous value +1 (mod 4).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- data_clk  input  1  sampling clock; same clock as the transmitter, all logic on its rising edge.
- reset  input  1  asynchronous active-low reset.
- DATA_IN  input  1  serial data, LSB first: INV[0..31], NAND[0..31], NOR[0..31], CLK[0..31].
- C_IN  input  2  frame select lines; increment once per 128-bit frame.
- INV_COUNT  output  32  last good frame bits 0-31.
- NAND_COUNT  output  32  last good frame bits 32-63.
- NOR_COUNT  output  32  last good frame bits 64-95.
- CLK_COUNT  output  32  last good frame bits 96-127.
- FRAME_ID  output  2  C_IN value held during the published frame.
- FRAME_VALID  output  1  one-cycle pulse when the count outputs update.
- SYNC_ERR  output  1  one-cycle pulse on a frame alignment violation.
- SEQ_ERR  output  1  one-cycle pulse with FRAME_VALID when the select did not increment by 1.
- LOCKED  output  1  high while aligned.
- ERR_COUNT  output  ERR_CNT_W  saturating count of SYNC_ERR plus SEQ_ERR events.

Behaviour:
- Reset is asynchronous, active-low, and may assert at any time; partial frames are discarded.
- Reset values: all count outputs 0, FRAME_ID 0, all pulses 0, LOCKED 0, ERR_COUNT 0, state HUNT, c_prev 0, bit_idx 0.
- c_prev is a register of the previous sampled C_IN, updated every cycle. An edge is a "transition" when C_IN != c_prev.
- Link timing: the sample on which a transition is seen carries bit 127 of the ending frame. The next sample is bit 0 of the new frame.
- HUNT state:
  - Ignore data.
  - On a transition, go to RECV with bit_idx 0 on the next sample.
  - The first frame after the transmitter leaves reset has no preceding transition, so it is always discarded.
- RECV state:
  - Each sample, shift DATA_IN into the MSB of a 128-bit shift register (shift right) and increment bit_idx.
  - bit_idx 0-126 with no transition: normal reception.
  - Transition at bit_idx < 127 (early): pulse SYNC_ERR, clear LOCKED, discard the frame. Treat this sample as a frame end: stay in RECV with bit_idx reset to 0.
  - bit_idx 127 with a transition: good frame.
    - Latch the outputs from {DATA_IN, shreg[127:1]}: bits [31:0] to INV_COUNT, and so on up to [127:96] to CLK_COUNT.
    - FRAME_ID <= c_prev. Pulse FRAME_VALID. Set LOCKED.
    - If CHECK_SEQ and C_IN != c_prev+1 (mod 4), pulse SEQ_ERR in the same cycle; data is still published.
    - Next sample is bit 0, state stays RECV.
  - bit_idx 127 with no transition (late): pulse SYNC_ERR, clear LOCKED, discard the frame, go to HUNT.
- Timing: outputs and pulses are registered. Frame outputs update on the edge that samples bit 127; FRAME_VALID is visible in the following cycle. FRAME_VALID and SYNC_ERR are never high together.
- Count outputs hold their value between good frames.
- ERR_COUNT:
  - Adds 1 per cycle in which SYNC_ERR or SEQ_ERR is high (SEQ_ERR never coincides with SYNC_ERR).
  - Saturates at all-ones and clears only on reset.
- bit_idx is 7 bits and never wraps silently; the bit_idx==127 check always comes first.

Test Plan:
- Back-to-back transmitter frames, C 0→1→2→3→0, with INV=0x12345678, NAND=0x9ABCDEF0, NOR=0x0F0F0F0F, CLK=0xDEADBEEF.
  - First frame is discarded.
  - Each later frame gives a FRAME_VALID pulse with exact values, FRAME_ID = prior C, LOCKED=1, and no errors, including across the 3→0 wrap.
- Force C_IN to change at bit 60 of a locked frame.
  - SYNC_ERR pulses once, LOCKED=0, outputs unchanged, ERR_COUNT+1.
  - The next full 128-bit frame is published with LOCKED=1.
- Hold C_IN constant for 200 cycles while locked.
  - SYNC_ERR at bit 127, state HUNT, no FRAME_VALID until a transition plus 128 good samples.
- Select sequence 1→3 at a frame boundary with CHECK_SEQ=1.
  - FRAME_VALID and SEQ_ERR pulse together and data is published.
  - With CHECK_SEQ=0, there is no SEQ_ERR.
- Assert reset asynchronously (mid-cycle) at bit 90.
  - All outputs go to 0 immediately and the state goes to HUNT.
  - After release, recovery follows the first-frame-discard rule.
- Inject 300 early transitions with ERR_CNT_W=8: ERR_COUNT saturates at 255 and holds.
